// File: rtl/spi_pkg.sv
// Shared types and width helpers for the generic SPI master and its SCLK generator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        WAIT,
        GAP
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Edge counter must reach 2*DATA_W, so it needs one bit above the clog2.
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w) + 1;
    endfunction

    function automatic int ss_idx_w(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: half-period divider plus edge counter that classifies each SCLK edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             run,
    input  logic             edges_en,
    input  logic [DIV_W-1:0] clk_div,
    output logic             half_tick,
    output logic             toggle_en,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             last_edge,
    output logic             xfer_end
);

    localparam int EW = edge_cnt_w(DATA_W);
    localparam logic [EW-1:0] EDGES     = EW'(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;

    // Edge k (1-based) is odd/leading when the count of edges already emitted is even.
    always_comb begin
        half_tick  = run && (div_cnt_q == clk_div);
        toggle_en  = half_tick && edges_en && (edge_cnt_q != EDGES);
        lead_edge  = toggle_en && !edge_cnt_q[0];
        trail_edge = toggle_en && edge_cnt_q[0];
        last_edge  = toggle_en && (edge_cnt_q == LAST_EDGE);
        xfer_end   = half_tick && edges_en && (edge_cnt_q == EDGES);

        div_cnt_d = '0;
        if (run && !half_tick) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        edge_cnt_d = edge_cnt_q;
        if (toggle_en) begin
            edge_cnt_d = edge_cnt_q + EW'(1);
        end
        if (restart) begin
            div_cnt_d  = '0;
            edge_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: word FSM, shift registers and slave-select decode.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            tx_data,
    input  logic [ss_idx_w(NUM_SS)-1:0]  ss_sel,
    input  logic                         cpol,
    input  logic                         cpha,
    input  logic [DIV_W-1:0]             clk_div,
    input  logic                         burst,
    input  logic                         frame_end,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         sclk,
    output logic                         mosi,
    input  logic                         miso,
    output logic [NUM_SS-1:0]            ss_n
);

    localparam int SS_W = ss_idx_w(NUM_SS);
    localparam logic [SS_W:0] NUM_SS_L = (SS_W + 1)'(NUM_SS);

    spi_state_e        state_q, state_d;
    logic [SS_W-1:0]   ss_idx_q, ss_idx_d;
    spi_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0]  clk_div_q, clk_div_d;
    logic              burst_q, burst_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;

    logic restart, run, edges_en, ss_valid, load, load_cpha, sample, shift;
    logic half_tick, toggle_en, lead_edge, trail_edge, last_edge, xfer_end;

    assign run      = (state_q == SETUP) || (state_q == XFER) || (state_q == GAP);
    assign edges_en = (state_q == SETUP) || (state_q == XFER);
    assign ss_valid = {1'b0, ss_sel} < NUM_SS_L;

    spi_sclk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .run        (run),
        .edges_en   (edges_en),
        .clk_div    (clk_div_q),
        .half_tick  (half_tick),
        .toggle_en  (toggle_en),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge),
        .xfer_end   (xfer_end)
    );

    always_comb begin
        state_d   = state_q;
        ss_idx_d  = ss_idx_q;
        mode_d    = mode_q;
        clk_div_d = clk_div_q;
        burst_d   = burst_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        restart   = 1'b0;
        load      = 1'b0;
        load_cpha = mode_q.cpha;

        // CPHA=1 shifts on leading edges starting with the MSB; CPHA=0 pre-loads the MSB.
        sample = mode_q.cpha ? trail_edge : lead_edge;
        shift  = mode_q.cpha ? lead_edge : (trail_edge && !last_edge);
        if (toggle_en) begin
            sclk_d = ~sclk_q;
            if (sample) begin
                rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
            end
            if (shift) begin
                mosi_d  = tx_sh_q[DATA_W-1];
                tx_sh_d = tx_sh_q << 1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && ss_valid) begin
                    state_d   = SETUP;
                    ss_idx_d  = ss_sel;
                    mode_d    = {cpol, cpha};
                    clk_div_d = clk_div;
                    burst_d   = burst;
                    sclk_d    = cpol;
                    load      = 1'b1;
                    load_cpha = cpha;
                    restart   = 1'b1;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer_end) begin
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    restart   = !burst_q;
                    state_d   = burst_q ? WAIT : GAP;
                end
            end
            WAIT: begin
                if (start) begin
                    state_d = SETUP;
                    burst_d = burst;
                    sclk_d  = mode_q.cpol;
                    load    = 1'b1;
                    restart = 1'b1;
                end else if (frame_end) begin
                    state_d = GAP;
                    restart = 1'b1;
                end
            end
            GAP: begin
                if (half_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            mosi_d  = tx_data[DATA_W-1];
            tx_sh_d = load_cpha ? tx_data : (tx_data << 1);
        end

        ss_n_d = '1;
        if (state_d inside {SETUP, XFER, WAIT}) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (ss_idx_d == SS_W'(i)) begin
                    ss_n_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_idx_q  <= '0;
            mode_q    <= '0;
            clk_div_q <= '0;
            burst_q   <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            ss_idx_q  <= ss_idx_d;
            mode_q    <= mode_d;
            clk_div_q <= clk_div_d;
            burst_q   <= burst_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
            ss_n_q    <= ss_n_d;
        end
    end

    assign ready   = (state_q == IDLE) || (state_q == WAIT);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen (DATA_W=8, NUM_SS=3) with an SPI slave model on sclk.
module tb_spi_master_gen;

    localparam int DATA_W = 8;
    localparam int NUM_SS = 3;
    localparam int DIV_W  = 8;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic       burst = 1'b0, frame_end = 1'b0;
    logic [7:0] tx_data = '0, clk_div = '0;
    logic [1:0] ss_sel = '0;
    logic       ready, busy, done, sclk, mosi, miso;
    logic [7:0] rx_data;
    logic [2:0] ss_n;

    int checks = 0, errors = 0;
    int done_total = 0, rise_total = 0, slave_total = 0, slave_base = 0;
    logic [7:0] slave_tx = '0, slave_rx = '0;
    logic       slave_cpha = 1'b0, loopback = 1'b0;

    always #5 clk = ~clk;

    spi_master_gen #(
        .DATA_W (DATA_W),
        .NUM_SS (NUM_SS),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .ss_sel    (ss_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
        .burst     (burst),
        .frame_end (frame_end),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    // Slave drives bit (7 - idx) where idx follows from how many sclk edges it has seen.
    function automatic logic slave_bit(input logic [7:0] d, input int rel, input logic pha);
        int idx;
        if (pha) idx = (rel <= 0) ? 0 : (rel - 1) / 2;
        else     idx = rel / 2;
        if (idx > 7) idx = 7;
        if (idx < 0) idx = 0;
        return d[7-idx];
    endfunction

    assign miso = loopback ? mosi : slave_bit(slave_tx, slave_total - slave_base, slave_cpha);

    always @(negedge clk) if (done === 1'b1) done_total++;

    always @(posedge sclk) rise_total++;

    always @(sclk) begin
        int e;
        e = slave_total - slave_base + 1;
        if (((e % 2) == 0) == (slave_cpha == 1'b1)) slave_rx = {slave_rx[6:0], mosi};
        slave_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                                 input logic pha, input logic [7:0] div, input logic bst,
                                 input logic st, input logic fe);
        tx_data   = tx;
        ss_sel    = sel;
        cpol      = pol;
        cpha      = pha;
        clk_div   = div;
        burst     = bst;
        start     = st;
        frame_end = fe;
        tick();
        start     = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic startWord(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                             input logic pha, input logic [7:0] div, input logic bst,
                             input logic fe, input logic [7:0] sdata, input logic spha);
        slave_tx   = sdata;
        slave_cpha = spha;
        applyStimulus(tx, sel, pol, pha, div, bst, 1'b1, fe);
        slave_base = slave_total;
    endtask

    task automatic waitDone(input string tag, input int cyc0, input int max,
                            input logic [2:0] ss_exp, output int cyc);
        logic ss_bad;
        ss_bad = 1'b0;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < max) begin
            if (ss_n !== ss_exp) ss_bad = 1'b1;
            tick();
            cyc++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_ss_held"}, 32'(ss_bad), 32'd0);
    endtask

    task automatic waitIdle(input string tag, input int max);
        int n;
        n = 0;
        while (!(ready === 1'b1 && busy === 1'b0) && n < max) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(ready && !busy), 32'd1);
    endtask

    logic       m_pol [3] = '{1'b0, 1'b1, 1'b1};
    logic       m_pha [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] m_div [3] = '{8'd0, 8'd2, 8'd1};
    logic [7:0] m_tx  [3] = '{8'h96, 8'h5A, 8'hC3};
    int         m_lat [3] = '{18, 52, 35};

    initial begin
        int cyc, d0, r0;

        repeat (2) tick();
        checkOutput("rst_ss_n", 32'(ss_n), 32'h7);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rx", 32'(rx_data), 32'd0);
        reset = 1'b0;
        tick();

        // Mode 0, H=2, loopback
        loopback = 1'b1;
        r0 = rise_total;
        startWord(8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("t1_ss_c1", 32'(ss_n), 32'h6);
        checkOutput("t1_mosi_c1", 32'(mosi), 32'd1);
        waitDone("t1", 1, 60, 3'b110, cyc);
        checkOutput("t1_latency", 32'(cyc), 32'd35);
        checkOutput("t1_rx", 32'(rx_data), 32'hA5);
        checkOutput("t1_ss_c35", 32'(ss_n), 32'h7);
        checkOutput("t1_rises", 32'(rise_total - r0), 32'd8);
        checkOutput("t1_sclk_idle", 32'(sclk), 32'd0);
        waitIdle("t1", 10);
        loopback = 1'b0;

        // Modes 1, 2, 3 against the slave model sending 0x3C
        for (int m = 0; m < 3; m++) begin
            startWord(m_tx[m], 2'd1, m_pol[m], m_pha[m], m_div[m], 1'b0, 1'b0, 8'h3C, m_pha[m]);
            checkOutput($sformatf("t2_m%0d_sclk_setup", m), 32'(sclk), 32'(m_pol[m]));
            waitDone($sformatf("t2_m%0d", m), 1, 80, 3'b101, cyc);
            checkOutput($sformatf("t2_m%0d_latency", m), 32'(cyc), 32'(m_lat[m]));
            checkOutput($sformatf("t2_m%0d_rx", m), 32'(rx_data), 32'h3C);
            checkOutput($sformatf("t2_m%0d_slave_rx", m), 32'(slave_rx), 32'(m_tx[m]));
            checkOutput($sformatf("t2_m%0d_sclk_idle", m), 32'(sclk), 32'(m_pol[m]));
            waitIdle($sformatf("t2_m%0d", m), 10);
        end

        // Burst of three words on ss_sel=2
        d0 = done_total;
        startWord(8'h11, 2'd2, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 8'hA1, 1'b0);
        waitDone("t3w1", 1, 60, 3'b011, cyc);
        checkOutput("t3w1_latency", 32'(cyc), 32'd35);
        checkOutput("t3w1_rx", 32'(rx_data), 32'hA1);
        checkOutput("t3w1_slave_rx", 32'(slave_rx), 32'h11);
        checkOutput("t3_wait_ready", 32'(ready), 32'd1);
        checkOutput("t3_wait_busy", 32'(busy), 32'd1);
        checkOutput("t3_wait_ss", 32'(ss_n), 32'h3);
        checkOutput("t3_wait_mosi", 32'(mosi), 32'd1);
        startWord(8'h22, 2'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'hB2, 1'b0);
        checkOutput("t3w2_sclk_c1", 32'(sclk), 32'd0);
        waitDone("t3w2", 1, 60, 3'b011, cyc);
        checkOutput("t3w2_latency", 32'(cyc), 32'd35);
        checkOutput("t3w2_rx", 32'(rx_data), 32'hB2);
        checkOutput("t3w2_slave_rx", 32'(slave_rx), 32'h22);
        startWord(8'h33, 2'd2, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'hC3, 1'b0);
        waitDone("t3w3", 1, 60, 3'b011, cyc);
        checkOutput("t3w3_latency", 32'(cyc), 32'd35);
        checkOutput("t3w3_rx", 32'(rx_data), 32'hC3);
        checkOutput("t3w3_slave_rx", 32'(slave_rx), 32'h33);
        checkOutput("t3_gap0_ss", 32'(ss_n), 32'h7);
        checkOutput("t3_gap0_ready", 32'(ready), 32'd0);
        tick();
        checkOutput("t3_gap1_ss", 32'(ss_n), 32'h7);
        checkOutput("t3_gap1_ready", 32'(ready), 32'd0);
        tick();
        checkOutput("t3_idle_ready", 32'(ready), 32'd1);
        checkOutput("t3_idle_busy", 32'(busy), 32'd0);
        checkOutput("t3_done_pulses", 32'(done_total - d0), 32'd3);

        // WAIT then frame_end; frame_end in IDLE; start+frame_end together
        startWord(8'h5B, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h99, 1'b0);
        waitDone("t4a", 1, 40, 3'b110, cyc);
        checkOutput("t4a_latency", 32'(cyc), 32'd18);
        checkOutput("t4a_rx", 32'(rx_data), 32'h99);
        applyStimulus(8'h00, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_gap_ss", 32'(ss_n), 32'h7);
        checkOutput("t4_gap_ready", 32'(ready), 32'd0);
        checkOutput("t4_gap_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("t4_idle_ready", 32'(ready), 32'd1);
        checkOutput("t4_idle_busy", 32'(busy), 32'd0);
        applyStimulus(8'h00, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_fe_idle_busy", 32'(busy), 32'd0);
        checkOutput("t4_fe_idle_ss", 32'(ss_n), 32'h7);
        startWord(8'h3C, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h66, 1'b0);
        waitDone("t4b", 1, 40, 3'b110, cyc);
        startWord(8'h81, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h7E, 1'b0);
        checkOutput("t4c_ss_c1", 32'(ss_n), 32'h6);
        checkOutput("t4c_ready_c1", 32'(ready), 32'd0);
        waitDone("t4c", 1, 40, 3'b110, cyc);
        checkOutput("t4c_latency", 32'(cyc), 32'd18);
        checkOutput("t4c_rx", 32'(rx_data), 32'h7E);
        checkOutput("t4c_slave_rx", 32'(slave_rx), 32'h81);
        waitIdle("t4c", 10);

        // Invalid slave index, then start while busy
        d0 = done_total;
        applyStimulus(8'h77, 2'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_bad_ready", 32'(ready), 32'd1);
        checkOutput("t5_bad_busy", 32'(busy), 32'd0);
        checkOutput("t5_bad_ss", 32'(ss_n), 32'h7);
        repeat (30) tick();
        checkOutput("t5_bad_no_done", 32'(done_total - d0), 32'd0);
        startWord(8'hF0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'hE7, 1'b0);
        repeat (3) tick();
        applyStimulus(8'h0F, 2'd0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        waitDone("t5b", 5, 40, 3'b101, cyc);
        checkOutput("t5b_latency", 32'(cyc), 32'd18);
        checkOutput("t5b_rx", 32'(rx_data), 32'hE7);
        checkOutput("t5b_slave_rx", 32'(slave_rx), 32'hF0);
        waitIdle("t5b", 10);
        repeat (25) tick();
        checkOutput("t5_one_done", 32'(done_total - d0), 32'd1);

        // Reset in the middle of a transfer
        startWord(8'hC6, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'hE1, 1'b0);
        repeat (9) tick();
        checkOutput("t6_pre_busy", 32'(busy), 32'd1);
        checkOutput("t6_pre_sclk", 32'(sclk), 32'd1);
        d0 = done_total;
        reset = 1'b1;
        tick();
        checkOutput("t6_ss", 32'(ss_n), 32'h7);
        checkOutput("t6_sclk", 32'(sclk), 32'd0);
        checkOutput("t6_rx", 32'(rx_data), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        checkOutput("t6_no_done", 32'(done_total - d0), 32'd0);
        checkOutput("t6_rx_held", 32'(rx_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
